hazard_backbus_ctrl: RTL and testbench

HAZARD_BACKBUS_CTRL -- requirements
Module: hazard_backbus_ctrl

---
 rtl/hazard_backbus_ctrl.sv | 177 +++++++++++++++++
 tb/tb_hazard_backbus_ctrl.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_backbus_ctrl.sv
// Hazard and forwarding back-bus controller.
// Owns the EX/MEM and MEM/WB registers, load-use and memory-wait stalls, and flush control.
module hazard_backbus_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic        ex_regWrite,
   input  logic        ex_memToReg,
   input  logic        ex_memReq,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_result,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   input  logic        branch_flush,
   output logic [37:0] MEM_BACK,
   output logic [37:0] WB_BACK,
   output logic        USE_MEM_BACK,
   output logic        USE_WB_BACK,
   output logic        stall_if_id,
   output logic        bubble_id_ex,
   output logic        flush_if_id,
   output logic        stall_ex_mem,
   output logic [7:0]  wait_cycles
);

   typedef enum logic {
      RUN,
      MWAIT
   } state_t;

   state_t state;
   state_t state_nx;

   logic        m_valid;
   logic        m_regWrite;
   logic        m_memToReg;
   logic        m_memReq;
   logic [4:0]  m_rd;
   logic [31:0] m_result;

   logic        w_valid;
   logic        w_regWrite;
   logic [4:0]  w_rd;
   logic [31:0] w_data;

   logic        pending_flush;
   logic        mem_stall;
   logic        load_use;
   logic        rs_hit;
   logic        rt_hit;
   logic        flush_go;
   logic [31:0] mem_wdata;

   // FSM state register; reset aborts any wait in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and memory-wait stall; the stall is raised in the
   // same cycle the access is first seen not ready
   always_comb begin
      state_nx  = state;
      mem_stall = 1'b0;
      unique case (state)
         RUN: begin
            if (m_valid && m_memReq && !dmem_ready) begin
               state_nx  = MWAIT;
               mem_stall = 1'b1;
            end
         end
         MWAIT: begin
            if (dmem_ready) begin
               state_nx = RUN;
            end else begin
               mem_stall = 1'b1;
            end
         end
      endcase
   end

   // Load-use detection against the load currently in EX; r0 never hazards
   always_comb begin
      rs_hit   = id_use_rs && (id_rs == ex_rd);
      rt_hit   = id_use_rt && (id_rt == ex_rd);
      load_use = ex_valid && ex_memToReg &&
                 (ex_rd != 5'd0) && (rs_hit || rt_hit);
   end

   // Pipeline control outputs, forced low while reset is held
   always_comb begin
      flush_go     = !mem_stall && (branch_flush || pending_flush);
      stall_ex_mem = rst_n && mem_stall;
      stall_if_id  = rst_n && (mem_stall || load_use);
      flush_if_id  = rst_n && flush_go;
      bubble_id_ex = rst_n &&
                     (flush_go || (load_use && !mem_stall));
   end

   // A flush seen during a memory stall is remembered until the
   // first unstalled cycle, where it is consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_flush <= 1'b0;
      end else if (mem_stall) begin
         pending_flush <= pending_flush || branch_flush;
      end else begin
         pending_flush <= 1'b0;
      end
   end

   // EX/MEM register: frozen while the memory access is outstanding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid    <= 1'b0;
         m_regWrite <= 1'b0;
         m_memToReg <= 1'b0;
         m_memReq   <= 1'b0;
         m_rd       <= 5'd0;
         m_result   <= 32'd0;
      end else if (!mem_stall) begin
         m_valid    <= ex_valid;
         m_regWrite <= ex_regWrite;
         m_memToReg <= ex_memToReg;
         m_memReq   <= ex_memReq;
         m_rd       <= ex_rd;
         m_result   <= ex_result;
      end
   end

   // Writeback data selects load data for loads, else the ALU result
   always_comb begin
      mem_wdata = m_memToReg ? dmem_rdata : m_result;
   end

   // MEM/WB register: takes a bubble on every waiting cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_valid    <= 1'b0;
         w_regWrite <= 1'b0;
         w_rd       <= 5'd0;
         w_data     <= 32'd0;
      end else if (mem_stall) begin
         w_valid    <= 1'b0;
      end else begin
         w_valid    <= m_valid;
         w_regWrite <= m_regWrite;
         w_rd       <= m_rd;
         w_data     <= mem_wdata;
      end
   end

   // Saturating count of memory-wait cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cycles <= 8'd0;
      end else if (mem_stall && (wait_cycles != 8'hFF)) begin
         wait_cycles <= wait_cycles + 8'd1;
      end
   end

   // Forwarding back-bus; MEM never forwards load data
   always_comb begin
      MEM_BACK     = {m_valid && m_regWrite, m_result, m_rd};
      WB_BACK      = {w_valid && w_regWrite, w_data, w_rd};
      USE_MEM_BACK = m_valid && !m_memToReg;
      USE_WB_BACK  = w_valid;
   end

endmodule

// File: tb/tb_hazard_backbus_ctrl.sv
// Self-checking bench for hazard_backbus_ctrl.
// Directed scenarios plus randomized traffic against a stage-level reference model.
module tb_hazard_backbus_ctrl;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_regWrite;
   logic        ex_memToReg;
   logic        ex_memReq;
   logic [4:0]  ex_rd;
   logic [31:0] ex_result;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_use_rs;
   logic        id_use_rt;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        branch_flush;
   logic [37:0] MEM_BACK;
   logic [37:0] WB_BACK;
   logic        USE_MEM_BACK;
   logic        USE_WB_BACK;
   logic        stall_if_id;
   logic        bubble_id_ex;
   logic        flush_if_id;
   logic        stall_ex_mem;
   logic [7:0]  wait_cycles;

   int checks;
   int passed;

   hazard_backbus_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_valid     (ex_valid),
      .ex_regWrite  (ex_regWrite),
      .ex_memToReg  (ex_memToReg),
      .ex_memReq    (ex_memReq),
      .ex_rd        (ex_rd),
      .ex_result    (ex_result),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .dmem_ready   (dmem_ready),
      .dmem_rdata   (dmem_rdata),
      .branch_flush (branch_flush),
      .MEM_BACK     (MEM_BACK),
      .WB_BACK      (WB_BACK),
      .USE_MEM_BACK (USE_MEM_BACK),
      .USE_WB_BACK  (USE_WB_BACK),
      .stall_if_id  (stall_if_id),
      .bubble_id_ex (bubble_id_ex),
      .flush_if_id  (flush_if_id),
      .stall_ex_mem (stall_ex_mem),
      .wait_cycles  (wait_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got running exp finished");
      $fatal(1);
   end

   function automatic logic [3:0] ctrl();
      return {stall_if_id, bubble_id_ex, flush_if_id, stall_ex_mem};
   endfunction

   task automatic quiet();
      ex_valid     = 1'b0;
      ex_regWrite  = 1'b0;
      ex_memToReg  = 1'b0;
      ex_memReq    = 1'b0;
      ex_rd        = 5'd0;
      ex_result    = 32'd0;
      id_rs        = 5'd0;
      id_rt        = 5'd0;
      id_use_rs    = 1'b0;
      id_use_rt    = 1'b0;
      dmem_ready   = 1'b1;
      dmem_rdata   = 32'd0;
      branch_flush = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      quiet();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic ex_load(input logic [4:0] rd);
      ex_valid    = 1'b1;
      ex_regWrite = 1'b1;
      ex_memToReg = 1'b1;
      ex_memReq   = 1'b1;
      ex_rd       = rd;
   endtask

   task automatic test_reset();
      quiet();
      rst_n = 1'b0;
      ex_load(5'd3);
      id_rs        = 5'd3;
      id_use_rs    = 1'b1;
      branch_flush = 1'b1;
      #1;
      checks++;
      if (ctrl() !== 4'b0000)
         $display("FAIL reset_ctrl got %b exp 0000", ctrl());
      else passed++;
      checks++;
      if (wait_cycles !== 8'd0)
         $display("FAIL reset_wait got %0d exp 0", wait_cycles);
      else passed++;
      checks++;
      if ({MEM_BACK, WB_BACK} !== 76'd0)
         $display("FAIL reset_bus got %h/%h exp 0", MEM_BACK, WB_BACK);
      else passed++;
      checks++;
      if ({USE_MEM_BACK, USE_WB_BACK} !== 2'b00)
         $display("FAIL reset_use got %b exp 00",
                  {USE_MEM_BACK, USE_WB_BACK});
      else passed++;
      tick();
      quiet();
      rst_n = 1'b1;
   endtask

   task automatic test_alu_forward();
      apply_reset();
      ex_valid    = 1'b1;
      ex_regWrite = 1'b1;
      ex_rd       = 5'd5;
      ex_result   = 32'h1234;
      #1;
      checks++;
      if (ctrl() !== 4'b0000)
         $display("FAIL alu_noctrl got %b exp 0000", ctrl());
      else passed++;
      tick();
      quiet();
      #1;
      checks++;
      if (MEM_BACK !== {1'b1, 32'h1234, 5'd5})
         $display("FAIL alu_mem_back got %h exp %h", MEM_BACK,
                  {1'b1, 32'h1234, 5'd5});
      else passed++;
      checks++;
      if (USE_MEM_BACK !== 1'b1)
         $display("FAIL alu_use_mem got %b exp 1", USE_MEM_BACK);
      else passed++;
      tick();
      #1;
      checks++;
      if (WB_BACK !== {1'b1, 32'h1234, 5'd5})
         $display("FAIL alu_wb_back got %h exp %h", WB_BACK,
                  {1'b1, 32'h1234, 5'd5});
      else passed++;
      checks++;
      if ({USE_WB_BACK, USE_MEM_BACK} !== 2'b10)
         $display("FAIL alu_use_wb got %b exp 10",
                  {USE_WB_BACK, USE_MEM_BACK});
      else passed++;
   endtask

   task automatic test_load_use();
      apply_reset();
      ex_load(5'd8);
      ex_result = 32'h100;
      id_rt     = 5'd8;
      id_use_rt = 1'b1;
      #1;
      checks++;
      if (ctrl() !== 4'b1100)
         $display("FAIL lu_stall got %b exp 1100", ctrl());
      else passed++;
      tick();
      quiet();
      id_rt     = 5'd8;
      id_use_rt = 1'b1;
      #1;
      checks++;
      if (ctrl() !== 4'b0000)
         $display("FAIL lu_one_cycle got %b exp 0000", ctrl());
      else passed++;
      checks++;
      if (USE_MEM_BACK !== 1'b0)
         $display("FAIL lu_no_fwd got %b exp 0", USE_MEM_BACK);
      else passed++;
      checks++;
      if (MEM_BACK !== {1'b1, 32'h100, 5'd8})
         $display("FAIL lu_mem_back got %h exp %h", MEM_BACK,
                  {1'b1, 32'h100, 5'd8});
      else passed++;
      tick();
      quiet();
      ex_load(5'd0);
      id_rt     = 5'd0;
      id_use_rt = 1'b1;
      id_rs     = 5'd0;
      id_use_rs = 1'b1;
      #1;
      checks++;
      if (ctrl() !== 4'b0000)
         $display("FAIL lu_r0 got %b exp 0000", ctrl());
      else passed++;
      tick();
      quiet();
   endtask

   task automatic test_mem_wait();
      apply_reset();
      ex_load(5'd9);
      tick();
      quiet();
      dmem_ready = 1'b0;
      #1;
      checks++;
      if (ctrl() !== 4'b1001)
         $display("FAIL mw_c1 got %b exp 1001", ctrl());
      else passed++;
      tick();
      branch_flush = 1'b1;
      #1;
      checks++;
      if (ctrl() !== 4'b1001)
         $display("FAIL mw_c2 got %b exp 1001", ctrl());
      else passed++;
      checks++;
      if (wait_cycles !== 8'd1)
         $display("FAIL mw_cnt1 got %0d exp 1", wait_cycles);
      else passed++;
      tick();
      branch_flush = 1'b0;
      #1;
      checks++;
      if (ctrl() !== 4'b1001)
         $display("FAIL mw_c3 got %b exp 1001", ctrl());
      else passed++;
      tick();
      dmem_ready = 1'b1;
      dmem_rdata = 32'hCAFE0001;
      #1;
      checks++;
      if (ctrl() !== 4'b0110)
         $display("FAIL mw_release got %b exp 0110", ctrl());
      else passed++;
      checks++;
      if (wait_cycles !== 8'd3)
         $display("FAIL mw_cnt3 got %0d exp 3", wait_cycles);
      else passed++;
      tick();
      dmem_rdata = 32'd0;
      #1;
      checks++;
      if (WB_BACK !== {1'b1, 32'hCAFE0001, 5'd9})
         $display("FAIL mw_wb got %h exp %h", WB_BACK,
                  {1'b1, 32'hCAFE0001, 5'd9});
      else passed++;
      checks++;
      if (ctrl() !== 4'b0000)
         $display("FAIL mw_flush_once got %b exp 0000", ctrl());
      else passed++;
      checks++;
      if (wait_cycles !== 8'd3)
         $display("FAIL mw_cnt_hold got %0d exp 3", wait_cycles);
      else passed++;
   endtask

   task automatic test_reset_mid_wait();
      apply_reset();
      ex_load(5'd4);
      tick();
      quiet();
      dmem_ready = 1'b0;
      ex_load(5'd6);
      id_rs     = 5'd6;
      id_use_rs = 1'b1;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ctrl() !== 4'b0000)
         $display("FAIL rmw_ctrl got %b exp 0000", ctrl());
      else passed++;
      checks++;
      if ({MEM_BACK, WB_BACK, USE_MEM_BACK, USE_WB_BACK} !== 78'd0)
         $display("FAIL rmw_bus got %h/%h exp 0", MEM_BACK, WB_BACK);
      else passed++;
      checks++;
      if (wait_cycles !== 8'd0)
         $display("FAIL rmw_cnt got %0d exp 0", wait_cycles);
      else passed++;
      tick();
      quiet();
      dmem_ready = 1'b0;
      rst_n = 1'b1;
      #1;
      checks++;
      if (ctrl() !== 4'b0000)
         $display("FAIL rmw_run got %b exp 0000", ctrl());
      else passed++;
      tick();
      #1;
      checks++;
      if ({ctrl(), wait_cycles} !== 12'd0)
         $display("FAIL rmw_after got %b/%0d exp 0000/0",
                  ctrl(), wait_cycles);
      else passed++;
      quiet();
   endtask

   task automatic test_saturate();
      apply_reset();
      ex_load(5'd7);
      tick();
      quiet();
      dmem_ready = 1'b0;
      repeat (300) tick();
      #1;
      checks++;
      if (wait_cycles !== 8'd255)
         $display("FAIL sat_cnt got %0d exp 255", wait_cycles);
      else passed++;
      checks++;
      if (stall_ex_mem !== 1'b1)
         $display("FAIL sat_stall got %b exp 1", stall_ex_mem);
      else passed++;
      tick();
      dmem_ready = 1'b1;
      #1;
      checks++;
      if ({stall_ex_mem, wait_cycles} !== {1'b0, 8'd255})
         $display("FAIL sat_nowrap got %b/%0d exp 0/255",
                  stall_ex_mem, wait_cycles);
      else passed++;
      tick();
   endtask

   task automatic test_random();
      logic        mv, mrw, mm2r, mreq;
      logic [4:0]  mrd;
      logic [31:0] mres;
      logic        wv, wrw;
      logic [4:0]  wrd;
      logic [31:0] wdat;
      logic        pend;
      int          waits;
      logic        busy, lu, fl;
      logic [3:0]  ectrl;
      apply_reset();
      mv = 0; mrw = 0; mm2r = 0; mreq = 0; mrd = 0; mres = 0;
      wv = 0; wrw = 0; wrd = 0; wdat = 0; pend = 0; waits = 0;
      for (int n = 0; n < 400; n++) begin
         ex_valid     = 1'($urandom_range(0, 1));
         ex_regWrite  = 1'($urandom_range(0, 1));
         ex_memToReg  = 1'($urandom_range(0, 1));
         ex_memReq    = ex_memToReg | 1'($urandom_range(0, 1));
         ex_rd        = 5'($urandom_range(0, 3));
         ex_result    = $urandom;
         id_rs        = 5'($urandom_range(0, 3));
         id_rt        = 5'($urandom_range(0, 3));
         id_use_rs    = 1'($urandom_range(0, 1));
         id_use_rt    = 1'($urandom_range(0, 1));
         dmem_ready   = ($urandom_range(0, 9) < 5);
         dmem_rdata   = $urandom;
         branch_flush = ($urandom_range(0, 4) == 0);
         #1;
         busy = mv && mreq && !dmem_ready;
         lu = ex_valid && ex_memToReg && ex_rd != 0 &&
              ((id_use_rs && id_rs == ex_rd) ||
               (id_use_rt && id_rt == ex_rd));
         fl = !busy && (branch_flush || pend);
         ectrl = {lu || busy, fl || (lu && !busy), fl, busy};
         checks++;
         if (ctrl() !== ectrl)
            $display("FAIL rnd_ctrl[%0d] got %b exp %b", n, ctrl(), ectrl);
         else passed++;
         checks++;
         if (wait_cycles !== 8'(waits))
            $display("FAIL rnd_wait[%0d] got %0d exp %0d",
                     n, wait_cycles, waits);
         else passed++;
         checks++;
         if (MEM_BACK !== {mv && mrw, mres, mrd})
            $display("FAIL rnd_mem[%0d] got %h exp %h",
                     n, MEM_BACK, {mv && mrw, mres, mrd});
         else passed++;
         checks++;
         if (WB_BACK !== {wv && wrw, wdat, wrd})
            $display("FAIL rnd_wb[%0d] got %h exp %h",
                     n, WB_BACK, {wv && wrw, wdat, wrd});
         else passed++;
         checks++;
         if ({USE_MEM_BACK, USE_WB_BACK} !== {mv && !mm2r, wv})
            $display("FAIL rnd_use[%0d] got %b exp %b", n,
                     {USE_MEM_BACK, USE_WB_BACK}, {mv && !mm2r, wv});
         else passed++;
         if (busy) begin
            if (waits < 255) waits++;
            pend = pend || branch_flush;
            wv   = 1'b0;
         end else begin
            pend = 1'b0;
            wv   = mv;
            wrw  = mrw;
            wrd  = mrd;
            wdat = mm2r ? dmem_rdata : mres;
            mv   = ex_valid;
            mrw  = ex_regWrite;
            mm2r = ex_memToReg;
            mreq = ex_memReq;
            mrd  = ex_rd;
            mres = ex_result;
         end
         tick();
      end
      quiet();
   endtask

   initial begin
      checks = 0;
      passed = 0;
      quiet();
      rst_n = 1'b0;
      tick();
      test_reset();
      test_alu_forward();
      test_load_use();
      test_mem_wait();
      test_reset_mid_wait();
      test_saturate();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
